// File: rtl/skolem_witness_search.sv
// Witness search: latches X, walks Y = 0,1,2,... through an external evaluator and returns the
// first satisfying Y. Defining WSEARCH_TIMEOUT_EN adds a MAX_ITER candidate limit.
module skolem_witness_search #(
  parameter int unsigned NX       = 40,
  parameter int unsigned NY       = 21,
  parameter int unsigned EVAL_LAT = 1,
  parameter int unsigned MAX_ITER = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [NX-1:0] x_in,
  output logic [NX-1:0] cand_x,
  output logic [NY-1:0] cand_y,
  input  logic          eval_sat,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_sat,
  output logic [NY-1:0] res_y,
  output logic [NY:0]   res_iters,
  output logic          res_timeout,
  output logic          busy
);

`ifdef WSEARCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [3:0] LAT        = 4'(EVAL_LAT);
  localparam logic [NY:0] ITER_FULL  = {1'b1, {NY{1'b0}}};
  localparam logic [NY:0] ITER_LIMIT = (NY+1)'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [NX-1:0] cand_x_q, cand_x_d;
  logic [NY-1:0] cand_y_q, cand_y_d;
  logic [NY:0]   iter_q, iter_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          res_sat_q, res_sat_d;
  logic [NY-1:0] res_y_q, res_y_d;
  logic [NY:0]   res_iters_q, res_iters_d;
  logic          res_timeout_q, res_timeout_d;

  logic [NY:0] iter_inc;
  logic        limit_hit;

  assign iter_inc  = iter_q + (NY+1)'(1);
  // True when the candidate being sampled is the MAX_ITER-th one.
  assign limit_hit = (32'(iter_q) + 32'd1) == MAX_ITER;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    state_d       = state_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    iter_d        = iter_q;
    wcnt_d        = wcnt_q;
    res_sat_d     = res_sat_q;
    res_y_d       = res_y_q;
    res_iters_d   = res_iters_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (x_valid) begin
          cand_x_d = x_in;
          cand_y_d = '0;
          iter_d   = '0;
          wcnt_d   = '0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (wcnt_q != LAT) begin
          wcnt_d = wcnt_q + 4'd1;
        end else if (eval_sat) begin
          res_sat_d     = 1'b1;
          res_y_d       = cand_y_q;
          res_iters_d   = iter_inc;
          res_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (&cand_y_q) begin
          // Exhaustion takes precedence over the limit, so it never reports a timeout.
          res_sat_d     = 1'b0;
          res_y_d       = '0;
          res_iters_d   = ITER_FULL;
          res_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (TIMEOUT_EN && limit_hit) begin
          res_sat_d     = 1'b0;
          res_y_d       = '0;
          res_iters_d   = ITER_LIMIT;
          res_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          cand_y_d = cand_y_q + NY'(1);
          iter_d   = iter_inc;
          wcnt_d   = '0;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      iter_q        <= '0;
      wcnt_q        <= '0;
      res_sat_q     <= 1'b0;
      res_y_q       <= '0;
      res_iters_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q       <= state_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      iter_q        <= iter_d;
      wcnt_q        <= wcnt_d;
      res_sat_q     <= res_sat_d;
      res_y_q       <= res_y_d;
      res_iters_q   <= res_iters_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign x_ready     = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign cand_x      = cand_x_q;
  assign cand_y      = cand_y_q;
  assign res_sat     = res_sat_q;
  assign res_y       = res_y_q;
  assign res_iters   = res_iters_q;
  assign res_timeout = res_timeout_q;

endmodule
